ex_div: RTL and testbench

- Multi-cycle 32-bit integer divider for the EX stage (DIV/DIVU).
- EX decodes the divide aluop from the ID/EX register outputs and drives start/operands.
- While the divide is busy, EX holds a stall request.
- The finished {remainder, quotient} goes to EX for the HI/LO write.

---
 rtl/ex_div.sv | 161 ++++++++++++++++
 tb/tb_ex_div.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// ============================================================================
// Module      : ex_div
// Description : Multi-cycle restoring divider for the EX stage (DIV/DIVU),
//               producing {remainder, quotient} one quotient bit per edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_div #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int                CNT_W  = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  C_ITER = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        DIV_FREE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } state_t;

    state_t                state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [DATA_W-1:0]     rem_q,      rem_d;
    logic [DATA_W-1:0]     quo_q,      quo_d;
    logic [DATA_W-1:0]     divisor_q,  divisor_d;
    logic                  sign_quo_q, sign_quo_d;
    logic                  sign_rem_q, sign_rem_d;
    logic [2*DATA_W-1:0]   result_q,   result_d;
    logic                  ready_q,    ready_d;

    logic [DATA_W-1:0]     abs_op1;
    logic [DATA_W-1:0]     abs_op2;
    logic [DATA_W:0]       shift_rem;
    logic [DATA_W:0]       trial;
    logic [DATA_W-1:0]     quo_fix;
    logic [DATA_W-1:0]     rem_fix;

    // Magnitudes for signed ops; the most negative value maps onto itself,
    // which is already its correct unsigned magnitude.
    assign abs_op1 = (signed_div_i && opdata1_i[DATA_W-1]) ? (DATA_W'(0) - opdata1_i) : opdata1_i;
    assign abs_op2 = (signed_div_i && opdata2_i[DATA_W-1]) ? (DATA_W'(0) - opdata2_i) : opdata2_i;

    // Remainder stays below the divisor, so the shifted partial remainder
    // needs only one extra bit for the trial subtraction.
    assign shift_rem = {rem_q, quo_q[DATA_W-1]};
    assign trial     = shift_rem - {1'b0, divisor_q};

    assign quo_fix = sign_quo_q ? (DATA_W'(0) - quo_q) : quo_q;
    assign rem_fix = sign_rem_q ? (DATA_W'(0) - rem_q) : rem_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            divisor_q  <= divisor_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        divisor_d  = divisor_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    divisor_d  = abs_op2;
                    quo_d      = abs_op1;
                    rem_d      = '0;
                    cnt_d      = '0;
                    sign_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    sign_rem_d = signed_div_i & opdata1_i[DATA_W-1];
                    state_d    = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                end
            end

            DIV_BYZERO: begin
                state_d  = DIV_END;
                result_d = '0;
                ready_d  = 1'b1;
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q != C_ITER) begin
                    if (!trial[DATA_W]) begin
                        rem_d = trial[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = shift_rem[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d  = DIV_END;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                end
            end

            DIV_END: begin
                if (!start_i || annul_i) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end

            default: begin
                state_d  = DIV_FREE;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_div.sv
// ============================================================================
// Module      : tb_ex_div
// Description : Directed self-checking bench for ex_div.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks   = 0;
    int failures = 0;

    ex_div #(.DATA_W(32)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Start an op, find the edge on which ready rises, check the result,
    // its hold while start stays high, and the clear after start drops.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        annul      = 1'b0;
        lat        = 0;
        for (int e = 1; e <= 50; e++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = e;
                break;
            end
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, result, exp);
        @(posedge clk);
        #1;
        check({tag, "_hold"}, {ready, result[62:0]}, {1'b1, exp[62:0]});
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_drop_rdy"}, 64'(ready), 64'd0);
        check({tag, "_drop_res"}, result, 64'd0);
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int e = 0; e < n; e++) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        rst        = 1'b0;
        signed_div = 1'b0;
        op1        = '0;
        op2        = '0;
        start      = 1'b0;
        annul      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rdy", 64'(ready), 64'd0);
        check("reset_res", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_div("u7_2",      1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 34);
        run_div("s-7_2",     1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34);
        run_div("s7_-2",     1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
        run_div("uFFFF_1",   1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 34);
        run_div("s_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
        run_div("uF9_2",     1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 34);
        run_div("uDEAD_16",  1'b0, 32'hDEADBEEF, 32'h00000010, 64'h0000000F_0DEADBEE, 34);
        run_div("div0",      1'b0, 32'h00001234, 32'h00000000, 64'h00000000_00000000, 2);

        // Annul partway through the iteration.
        @(negedge clk);
        signed_div = 1'b0;
        op1        = 32'd1000;
        op2        = 32'd3;
        start      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("annul_rdy", 64'(ready), 64'd0);
        @(negedge clk);
        annul = 1'b0;
        expect_quiet("annul_quiet", 40);
        run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

        // Asynchronous reset between edges while iterating.
        @(negedge clk);
        op1   = 32'd100;
        op2   = 32'd7;
        start = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst_on_rdy", 64'(ready), 64'd0);
        check("arst_on_res", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        expect_quiet("arst_on_quiet", 40);

        // Asynchronous reset between edges while a result is held.
        @(negedge clk);
        op1   = 32'd7;
        op2   = 32'd2;
        start = 1'b1;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk);
            #1;
            if (ready) break;
        end
        check("arst_end_pre", result, 64'h00000001_00000003);
        #2;
        rst = 1'b0;
        #1;
        check("arst_end_rdy", 64'(ready), 64'd0);
        check("arst_end_res", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        expect_quiet("arst_end_quiet", 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
